data_ctrl: RTL and testbench
============================

# data_ctrl

Frame buffer and reorder controller at the input of the FFT peripheral. It accepts a stream of 32-bit samples and stores one frame of N = 2^ADDR_W samples in an internal single-port-per-side RAM. It then streams the frame back out in bit-reversed order, ready for an in-place radix-2 FFT core. Both sides use a valid/ready handshake; input and output phases alternate and never overlap.

## Interface
Parameters:
- DATA_W, 32, sample payload width.
- ADDR_W, 9, log2 of frame length (N = 512).

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_data  in  DATA_W+1  [DATA_W-1:0] sample payload; [DATA_W] frame-sync flag.
- i_data_valid  in  1  upstream sample valid.
- o_data_ready  out  1  block can accept a sample.
- o_data  out  DATA_W  reordered sample out.
- o_data_valid  out  1  o_data valid.
- i_data_ready  in  1  downstream accepts o_data.
- index  out  ADDR_W  current element counter (write slot in FILL, output element in DRAIN).
- indexNext  out  ADDR_W  combinational index+1 mod N.

## Operation
- States: FILL, PREP, DRAIN. Reset state is FILL.
- FILL:
  - o_data_ready=1.
  - Accept when i_data_valid & o_data_ready: write payload to mem[index], then index<=indexNext.
  - If frame-sync=1 on an accepted beat: write to mem[0], index<=1. This restarts the frame.
  - Accepting at index==N-1 (without sync) -> PREP, index<=0.
- PREP:
  - One cycle; o_data_ready=0, o_data_valid=0.
  - RAM read of mem[rd_addr(0)] into the o_data register.
  - -> DRAIN.
- DRAIN:
  - o_data_valid=1, o_data_ready=0; o_data = mem[rd_addr(index)].
  - On i_data_ready: o_data register loads mem[rd_addr(indexNext)], index<=indexNext.
  - If i_data_ready is low: o_data, o_data_valid and index hold.
  - Accepting at index==N-1 -> FILL, index<=0, o_data_valid<=0.
- rd_addr(k) = bit-reverse of k over ADDR_W bits when DATACTRL_BITREV_EN is defined, else k.
- i_data_valid and frame-sync are ignored outside FILL. i_data_ready is ignored outside DRAIN.
- indexNext wraps N-1 -> 0.

## Timing
- Reset values: state FILL, index 0, indexNext 1, o_data 0, o_data_valid 0.
- o_data_ready = (state==FILL) & ~i_rst, so it is 0 during reset.
- Reset asserted mid-frame aborts the frame. The next edge after release starts FILL at index 0; RAM contents are not cleared.
- Fill takes N accepted beats, one per cycle maximum. o_data_ready drops the cycle after the N-th accept.
- First output valid 2 cycles after the last accept (one cycle for the FILL->PREP edge, one for PREP).
- DRAIN delivers one sample per cycle while i_data_ready=1. Minimum frame period is 2N+1 cycles.
- o_data_ready rises the cycle after the last output beat is accepted.

## Configuration
- DATACTRL_BITREV_EN defined: output order is bit-reversed (k -> rev_ADDR_W(k)).
- Not defined: output order is natural (k -> k); everything else is identical.

## Test plan
- Reset: hold i_rst=1 for 5 cycles -> o_data_valid=0, o_data_ready=0, index=0, indexNext=1. Release -> o_data_ready=1 on the next cycle.
- Bit-reversed frame (BITREV_EN, ready/valid held 1, i_data=k on beat k, k=0..511) -> outputs in order 0,256,128,384,64,…,511. o_data_valid appears 2 cycles after the 512th accept; 1025-cycle frame period.
- Natural order (macro undefined), same stimulus -> outputs 0,1,2,…,511.
- Backpressure: toggle i_data_ready 1,0,0,1 in DRAIN -> o_data and index hold during the low cycles, with no sample lost or duplicated. Gaps in i_data_valid during FILL -> index advances only on accepts.
- Frame sync: during FILL at index=100, send payload 0xAAAA with bit 32=1 -> mem[0]=0xAAAA, index=1. Completing 511 more beats -> first output 0xAAAA.
- Mid-frame reset: assert i_rst at DRAIN index 37 -> next cycle state FILL, index 0, o_data_valid 0. A new full frame then drains correctly.

Source files
------------

// File: rtl/data_ctrl.sv
// data_ctrl: frame buffer + reorder controller feeding the FFT core.
// Fills one N=2^ADDR_W frame, then drains it in rd_addr() order.
//
// Build option: define DATACTRL_BITREV_EN for bit-reversed drain order;
// left undefined the frame drains in natural order.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_data[DATA_W:0]    payload [DATA_W-1:0], frame-sync flag [DATA_W]
//   i_data_valid        upstream beat valid
//   o_data_ready        accepting samples (FILL and not in reset)
//   o_data, o_data_valid  reordered sample stream
//   i_data_ready        downstream accepts o_data
//   index, indexNext    element counter and its mod-N successor
module data_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W:0]   i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic [ADDR_W-1:0] index,
  output logic [ADDR_W-1:0] indexNext
);

  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {
    FILL,
    PREP,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   odat_q;

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic                rd_en;
  logic [ADDR_W-1:0]   raddr;
  logic                accept;
  logic                sync;

  logic [DATA_W-1:0]   mem [N];

  function automatic logic [ADDR_W-1:0] rd_addr(
    input logic [ADDR_W-1:0] k
  );
    logic [ADDR_W-1:0] r;
`ifdef DATACTRL_BITREV_EN
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = k[ADDR_W-1-i];
    end
`else
    r = k;
`endif
    return r;
  endfunction

  assign index        = index_q;
  assign indexNext    = index_q + 1'b1;
  assign o_data       = odat_q;
  assign o_data_valid = vld_q;
  assign o_data_ready = (state_q == FILL) & ~i_rst;
  assign accept       = i_data_valid & o_data_ready;
  assign sync         = i_data[DATA_W];

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    vld_d   = vld_q;
    we      = 1'b0;
    waddr   = index_q;
    rd_en   = 1'b0;
    raddr   = rd_addr(indexNext);
    unique case (state_q)
      FILL: begin
        vld_d = 1'b0;
        if (accept) begin
          we = 1'b1;
          if (sync) begin
            // sync beat restarts the frame at slot 0
            waddr   = '0;
            index_d = ADDR_W'(1);
          end else if (index_q == LAST) begin
            state_d = PREP;
            index_d = '0;
          end else begin
            index_d = indexNext;
          end
        end
      end
      PREP: begin
        // prefetch first element so DRAIN starts with valid data
        rd_en   = 1'b1;
        raddr   = rd_addr('0);
        vld_d   = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (i_data_ready) begin
          rd_en   = 1'b1;
          index_d = indexNext;
          if (index_q == LAST) begin
            state_d = FILL;
            vld_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = FILL;
        index_d = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FILL;
      index_q <= '0;
      vld_q   <= 1'b0;
      odat_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      vld_q   <= vld_d;
      if (rd_en) begin
        odat_q <= mem[raddr];
      end
    end
  end

  // RAM is never cleared; reset only blocks writes via o_data_ready
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[waddr] <= i_data[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_data_ctrl.sv
// tb_data_ctrl: directed bench for data_ctrl.
// Fill/drain, backpressure, frame sync, period and mid-frame reset.
module tb_data_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int N  = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW:0]   din = '0;
  logic          din_v = 1'b0;
  logic          rdy_o;
  logic [DW-1:0] dout;
  logic          dout_v;
  logic          dn_rdy = 1'b0;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nx;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mm [N];

  data_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (din),
    .i_data_valid(din_v),
    .o_data_ready(rdy_o),
    .o_data      (dout),
    .o_data_valid(dout_v),
    .i_data_ready(dn_rdy),
    .index       (idx),
    .indexNext   (idx_nx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rd(input int k);
    int r;
    r = 0;
`ifdef DATACTRL_BITREV_EN
    for (int i = 0; i < AW; i++) begin
      if (k[i]) r = r | (1 << (AW - 1 - i));
    end
`else
    r = k;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] v, input logic s);
    din   = {s, v};
    din_v = 1'b1;
    step();
    din_v = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int k = 0; k < N; k++) begin
      send(base + DW'(k), 1'b0);
      mm[k] = base + DW'(k);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!dout_v && n < 4) begin
      step();
      n++;
    end
    chk(tag, 64'(dout_v), 64'd1);
  endtask

  task automatic drain_full(input string tag);
    wait_valid({tag, "_start"});
    dn_rdy = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk({tag, "_vld"}, 64'(dout_v), 64'd1);
      chk({tag, "_dat"}, 64'(dout), 64'(mm[rd(k)]));
      chk({tag, "_idx"}, 64'(idx), 64'(k % N));
      step();
    end
    dn_rdy = 1'b0;
    chk({tag, "_endvld"}, 64'(dout_v), 64'd0);
    chk({tag, "_endrdy"}, 64'(rdy_o), 64'd1);
  endtask

  initial begin
    int k;
    int cyc;
    int cin;
    int cout;
    int first;
    logic acc_in;
    logic acc_out;
    logic [DW-1:0] v;

    // reset held 5 cycles
    rst = 1'b1;
    repeat (5) step();
    chk("rst_vld", 64'(dout_v), 64'd0);
    chk("rst_rdy", 64'(rdy_o), 64'd0);
    chk("rst_idx", 64'(idx), 64'd0);
    chk("rst_idxnx", 64'(idx_nx), 64'd1);
    chk("rst_dout", 64'(dout), 64'd0);
    rst = 1'b0;
    step();
    chk("rel_rdy", 64'(rdy_o), 64'd1);
    chk("rel_idx", 64'(idx), 64'd0);

    // fill with gaps in valid
    for (int j = 0; j < N; j++) begin
      if (j % 64 == 3) begin
        din_v = 1'b0;
        step();
        chk("gap_idx", 64'(idx), 64'(j));
      end
      v = 32'h1000 + DW'(j);
      send(v, 1'b0);
      mm[j] = v;
    end
    chk("prep_rdy", 64'(rdy_o), 64'd0);
    chk("prep_vld", 64'(dout_v), 64'd0);
    step();
    chk("lat_vld", 64'(dout_v), 64'd1);
    chk("lat_dat", 64'(dout), 64'(mm[rd(0)]));

    // drain with 1,0,0,1 backpressure on early elements
    k = 0;
    cyc = 0;
    while (k < N && cyc < 3 * N) begin
      dn_rdy = !(k < 40 && (cyc % 4 == 1 || cyc % 4 == 2));
      chk("bp_vld", 64'(dout_v), 64'd1);
      chk("bp_dat", 64'(dout), 64'(mm[rd(k)]));
      chk("bp_idx", 64'(idx), 64'(k));
      step();
      if (dn_rdy) k++;
      cyc++;
    end
    dn_rdy = 1'b0;
    chk("bp_count", 64'(k), 64'(N));
    chk("bp_endvld", 64'(dout_v), 64'd0);
    chk("bp_endrdy", 64'(rdy_o), 64'd1);

    // full-speed frame: period 2N+1, first valid 2 cycles after last accept
    cin = 0;
    cout = 0;
    first = -1;
    dn_rdy = 1'b1;
    for (int c = 0; c < 2 * N + 1; c++) begin
      v = 32'hC0DE0000 ^ DW'(cin * 7);
      din = {1'b0, v};
      din_v = 1'b1;
      acc_in = rdy_o;
      acc_out = dout_v;
      if (dout_v) begin
        if (first < 0) first = c;
        chk("fs_dat", 64'(dout), 64'(mm[rd(cout)]));
        chk("fs_idx", 64'(idx), 64'(cout));
      end
      step();
      if (acc_in) begin
        mm[cin] = v;
        cin++;
      end
      if (acc_out) cout++;
    end
    din_v = 1'b0;
    dn_rdy = 1'b0;
    chk("fs_in", 64'(cin), 64'(N));
    chk("fs_out", 64'(cout), 64'(N));
    chk("fs_first", 64'(first), 64'(N + 1));
    chk("fs_rdy", 64'(rdy_o), 64'd1);

    // frame sync at index 100
    for (int j = 0; j < 100; j++) begin
      v = 32'h5000 + DW'(j);
      send(v, 1'b0);
      mm[j] = v;
    end
    chk("sync_pre_idx", 64'(idx), 64'd100);
    send(32'h0000AAAA, 1'b1);
    mm[0] = 32'h0000AAAA;
    chk("sync_idx", 64'(idx), 64'd1);
    chk("sync_idxnx", 64'(idx_nx), 64'd2);
    for (int j = 1; j < N; j++) begin
      v = 32'h6000 + DW'(j);
      send(v, 1'b0);
      mm[j] = v;
    end
    wait_valid("sync_wait");
    chk("sync_first", 64'(dout), 64'h0000AAAA);
    drain_full("sync");

    // reset mid-drain at index 37
    fill(32'h7000);
    wait_valid("mr_wait");
    dn_rdy = 1'b1;
    for (int j = 0; j < 37; j++) begin
      chk("mr_dat", 64'(dout), 64'(mm[rd(j)]));
      step();
    end
    chk("mr_idx37", 64'(idx), 64'd37);
    rst = 1'b1;
    step();
    dn_rdy = 1'b0;
    chk("mr_vld", 64'(dout_v), 64'd0);
    chk("mr_idx", 64'(idx), 64'd0);
    chk("mr_rdy", 64'(rdy_o), 64'd0);
    rst = 1'b0;
    step();
    chk("mr_rel_rdy", 64'(rdy_o), 64'd1);
    chk("mr_rel_idx", 64'(idx), 64'd0);
    fill(32'h8000);
    drain_full("mr_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
